polyveck_pack_eta: RTL and testbench

// Reader/consumer of the K-polynomial eta vector emitted by the uniform-eta sampler; packs each

---
 rtl/polyveck_pack_eta.sv | 117 +++++++++++
 tb/tb_polyveck_pack_eta.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/polyveck_pack_eta.sv
// Packs a K-polynomial eta vector of signed coefficients into 4-bit nibbles (t = ETA - c),
// CPC coefficients per cycle. It uses a rtr/rts handshake and a sticky out-of-range flag.
module polyveck_pack_eta #(
  parameter int K   = 6,
  parameter int N   = 256,
  parameter int ETA = 4,
  parameter int CPC = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rtr,
  input  logic [K*N*32-1:0]    linear_v,
  output logic [K*N*4-1:0]     linear_packed,
  output logic                 rts,
  output logic                 err
);

  localparam int CHUNKS = N / CPC;
  localparam int PW     = (K > 1) ? $clog2(K) : 1;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int IW     = $clog2(K * N) + 1;

  localparam logic [PW-1:0]        LAST_POLY  = PW'(K - 1);
  localparam logic [CW-1:0]        LAST_CHUNK = CW'(CHUNKS - 1);
  localparam logic signed [31:0]   ETA_POS    = 32'(ETA);
  localparam logic signed [31:0]   ETA_NEG    = -ETA_POS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_PACK,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [PW-1:0]     poly_idx;
  logic [CW-1:0]     chunk_idx;
  logic              last_chunk;
  logic [IW-1:0]     chunk_base;

  logic signed [31:0] coeff [CPC];
  logic [3:0]         nib   [CPC];
  logic [CPC-1:0]     bad;

  assign last_chunk = (poly_idx == LAST_POLY) && (chunk_idx == LAST_CHUNK);
  assign chunk_base = IW'(poly_idx) * IW'(N) + IW'(chunk_idx) * IW'(CPC);
  assign rts        = (state == S_DONE);

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: next-state defaults to the current state so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE: state_next = S_WAIT;
      S_WAIT: if (rtr) state_next = S_LOAD;
      S_LOAD: state_next = S_PACK;
      S_PACK: if (last_chunk) state_next = S_DONE;
      S_DONE: if (!rtr) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Slice the current chunk straight out of the input; upstream holds linear_v stable.
  always_comb begin
    for (int k = 0; k < CPC; k++) begin
      coeff[k] = linear_v[32*(int'(chunk_base) + k) +: 32];
      nib[k]   = 4'(ETA_POS - coeff[k]);
      bad[k]   = (coeff[k] > ETA_POS) || (coeff[k] < ETA_NEG);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      poly_idx  <= '0;
      chunk_idx <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          poly_idx  <= '0;
          chunk_idx <= '0;
          err       <= 1'b0;
        end
        S_PACK: begin
          err <= err | (|bad);
          if (chunk_idx == LAST_CHUNK) begin
            chunk_idx <= '0;
            // Wrap the poly index after the final chunk so the read slice stays in range.
            poly_idx  <= last_chunk ? '0 : poly_idx + 1'b1;
          end else begin
            chunk_idx <= chunk_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the packed result is a plain register bank, so it is cleared on reset like any flop.
    if (!reset) begin
      linear_packed <= '0;
    end else if (state == S_PACK) begin
      for (int k = 0; k < CPC; k++) begin
        linear_packed[4*(int'(chunk_base) + k) +: 4] <= nib[k];
      end
    end
  end

endmodule

// File: tb/tb_polyveck_pack_eta.sv
// Self-checking bench for polyveck_pack_eta: table-driven patterns plus random data against an
// array-based reference model, and hand-written reset / handshake sequences.
module tb_polyveck_pack_eta;

  localparam int K   = 6;
  localparam int N   = 256;
  localparam int ETA = 4;
  localparam int CPC = 8;
  localparam int RUN_EDGES = 1 + 1 + K * N / CPC;   // sampling edge + LOAD + PACK edges

  logic                 clock;
  logic                 reset;
  logic                 rtr;
  logic [K*N*32-1:0]    linear_v;
  logic [K*N*4-1:0]     linear_packed;
  logic                 rts;
  logic                 err;

  polyveck_pack_eta #(.K(K), .N(N), .ETA(ETA), .CPC(CPC)) dut (
    .clock        (clock),
    .reset        (reset),
    .rtr          (rtr),
    .linear_v     (linear_v),
    .linear_packed(linear_packed),
    .rts          (rts),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int               coeffs [K][N];
  logic [K*N*4-1:0] exp_packed;
  logic             exp_err;

  typedef struct {
    int         mode;
    bit         fixed;
    bit         toggle;
    logic       exp_err;
    logic [7:0] exp_b0;
    logic [31:0] exp_top;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_packed(input string name);
    int bad_nibs = 0;
    for (int i = 0; i < K * N; i++)
      if (linear_packed[4*i +: 4] !== exp_packed[4*i +: 4]) bad_nibs++;
    check(name, 64'(bad_nibs), 64'd0);
  endtask

  // Reference model: coefficients as plain integers, nibble = low 4 bits of ETA - c.
  task automatic build_expected();
    exp_err = 1'b0;
    for (int x = 0; x < K; x++)
      for (int j = 0; j < N; j++) begin
        exp_packed[4*(N*x + j) +: 4] = 4'(ETA - coeffs[x][j]);
        if (coeffs[x][j] > ETA || coeffs[x][j] < -ETA) exp_err = 1'b1;
        linear_v[32*(N*x + j) +: 32] = 32'(coeffs[x][j]);
      end
  endtask

  task automatic fill(input int mode);
    for (int x = 0; x < K; x++)
      for (int j = 0; j < N; j++)
        case (mode)
          1:       coeffs[x][j] = (j % 9) - 4;
          3, 5:    coeffs[x][j] = int'($urandom_range(0, 2 * ETA)) - ETA;
          default: coeffs[x][j] = 0;
        endcase
    if (mode == 2) begin
      coeffs[0][0] = -4;
      coeffs[0][1] = 5;
    end
    if (mode == 4)
      for (int j = 248; j < 256; j++) coeffs[5][j] = -4;
    if (mode == 5)
      for (int r = 0; r < 3; r++)
        coeffs[$urandom_range(0, K-1)][$urandom_range(0, N-1)] = int'($urandom);
    build_expected();
  endtask

  // Raise rtr while the DUT sits in WAIT and count edges until rts appears.
  task automatic do_run(input string tag, input bit toggle);
    int edges = 0;
    @(negedge clock);
    rtr = 1'b1;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clock);
      #1;
      if (toggle && e == 50) rtr = 1'b0;
      if (toggle && e == 54) rtr = 1'b1;
      if (rts) begin
        edges = e;
        break;
      end
    end
    check({tag, "_rts_latency"}, 64'(edges), 64'(RUN_EDGES));
  endtask

  // Hold rtr in DONE, then release and return to WAIT.
  task automatic hold_and_release(input string tag, input int hold);
    logic [K*N*4-1:0] snap;
    bit ok = 1'b1;
    snap = linear_packed;
    for (int c = 0; c < hold; c++) begin
      @(posedge clock);
      #1;
      if (!rts || linear_packed !== snap || err !== exp_err) ok = 1'b0;
    end
    check({tag, "_done_stable"}, 64'(ok), 64'd1);
    @(negedge clock);
    rtr = 1'b0;
    @(posedge clock);
    #1;
    check({tag, "_rts_drop"}, 64'(rts), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    check_packed({tag, "_held_in_wait"});
  endtask

  initial begin
    vecs[0] = '{mode: 0, fixed: 1, toggle: 0, exp_err: 0, exp_b0: 8'h44, exp_top: 32'h44444444};
    vecs[1] = '{mode: 1, fixed: 1, toggle: 0, exp_err: 0, exp_b0: 8'h78, exp_top: 32'h56780123};
    vecs[2] = '{mode: 2, fixed: 1, toggle: 0, exp_err: 1, exp_b0: 8'hF8, exp_top: 32'h44444444};
    vecs[3] = '{mode: 3, fixed: 0, toggle: 1, exp_err: 0, exp_b0: 8'h00, exp_top: 32'h0};
    vecs[4] = '{mode: 4, fixed: 1, toggle: 0, exp_err: 0, exp_b0: 8'h44, exp_top: 32'h88888888};
    vecs[5] = '{mode: 5, fixed: 0, toggle: 0, exp_err: 1, exp_b0: 8'h00, exp_top: 32'h0};
    vecs[6] = '{mode: 3, fixed: 0, toggle: 0, exp_err: 0, exp_b0: 8'h00, exp_top: 32'h0};

    reset    = 1'b0;
    rtr      = 1'b0;
    linear_v = '0;
    #1;
    check("reset_rts", 64'(rts), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_packed_zero", 64'(linear_packed == '0), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      fill(vecs[i].mode);
      do_run(tag, vecs[i].toggle);
      check_packed({tag, "_packed"});
      check({tag, "_err"}, 64'(err), 64'(exp_err));
      if (vecs[i].fixed) begin
        check({tag, "_byte0"}, 64'(linear_packed[7:0]), 64'(vecs[i].exp_b0));
        check({tag, "_top32"}, 64'(linear_packed[K*N*4-1 -: 32]), 64'(vecs[i].exp_top));
        check({tag, "_err_table"}, 64'(err), 64'(vecs[i].exp_err));
      end
      hold_and_release(tag, (i == 0) ? 10 : 3);
    end

    // Reset in the middle of PACK, then a clean rerun of the all-zero pattern.
    fill(2);
    @(negedge clock);
    rtr = 1'b1;
    for (int e = 0; e < 2 + 100; e++) @(posedge clock);
    #1;
    check("midrun_err_before_reset", 64'(err), 64'd1);
    reset = 1'b0;
    #1;
    check("midrun_reset_rts", 64'(rts), 64'd0);
    check("midrun_reset_err", 64'(err), 64'd0);
    check("midrun_reset_packed_zero", 64'(linear_packed == '0), 64'd1);
    rtr = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    fill(0);
    do_run("rerun", 1'b0);
    check_packed("rerun_packed");
    check("rerun_err", 64'(err), 64'd0);
    hold_and_release("rerun", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
